// File: rtl/fetch_sequencer.sv
// Instruction fetch and PC sequencing: fetches over req/ack, holds the instruction
// while it executes, resolves branch/jump into the next PC and counts retirements.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [31:0] retire_count,
    output logic [1:0]  dbg_state
);

    // Handshake: imem_req stays high with imem_addr stable from the first FETCH
    // cycle until the edge where imem_ack is sampled high; that edge transfers
    // imem_rdata. exec_done is a one-cycle qualifier sampled only in EXEC.
    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retire_count;
    logic        w_load_instr;
    logic        w_retire;
    logic        w_taken;
    logic [31:0] w_pc4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_next_pc;

    always_comb begin
        w_next_state = r_state;
        w_load_instr = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_RST:   w_next_state = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    w_load_instr = 1'b1;
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    w_retire     = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end
            default:  w_next_state = ST_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Branches other than beq/bne fall through to pc+4; jump overrides branch.
    always_comb begin
        w_pc4       = r_pc + 32'd4;
        w_j_target  = {w_pc4[31:28], r_instr[25:0], 2'b00};
        w_br_target = w_pc4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
        w_taken     = 1'b0;
        if (branch) begin
            if (r_instr[31:26] == 6'b000100) begin
                w_taken = zero;
            end else if (r_instr[31:26] == 6'b000101) begin
                w_taken = ~zero;
            end
        end
        if (jump) begin
            w_next_pc = w_j_target;
        end else if (w_taken) begin
            w_next_pc = w_br_target;
        end else begin
            w_next_pc = w_pc4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc           <= RESET_PC;
            r_instr        <= 32'd0;
            r_retire_count <= 32'd0;
        end else begin
            if (w_load_instr) begin
                r_instr <= imem_rdata;
            end
            if (w_retire) begin
                r_pc           <= w_next_pc;
                r_retire_count <= r_retire_count + 32'd1;
            end
        end
    end

    assign imem_req     = (r_state == ST_FETCH);
    assign instr_valid  = (r_state == ST_EXEC);
    assign imem_addr    = r_pc;
    assign pc           = r_pc;
    assign instr        = r_instr;
    assign opcode       = r_instr[31:26];
    assign retire_count = r_retire_count;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (default and high-region RESET_PC) share
// all inputs; a vector table, directed reset sequences and random instructions.
module tb_fetch_sequencer;

    localparam logic [31:0] PC1 = 32'hF000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        exec_done = 1'b0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        zero = 1'b0;

    logic        a_req, b_req, a_valid, b_valid;
    logic [31:0] a_addr, b_addr, a_instr, b_instr, a_pc, b_pc, a_cnt, b_cnt;
    logic [5:0]  a_op, b_op;
    logic [1:0]  a_st, b_st;

    fetch_sequencer u0 (
        .clk(clk), .rst_n(rst_n), .imem_req(a_req), .imem_addr(a_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(a_instr), .opcode(a_op),
        .instr_valid(a_valid), .exec_done(exec_done), .branch(branch), .jump(jump),
        .zero(zero), .pc(a_pc), .retire_count(a_cnt), .dbg_state(a_st)
    );

    fetch_sequencer #(.RESET_PC(PC1)) u1 (
        .clk(clk), .rst_n(rst_n), .imem_req(b_req), .imem_addr(b_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(b_instr), .opcode(b_op),
        .instr_valid(b_valid), .exec_done(exec_done), .branch(branch), .jump(jump),
        .zero(zero), .pc(b_pc), .retire_count(b_cnt), .dbg_state(b_st)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_pc0, m_pc1, m_cnt, m_instr;

    typedef struct {
        logic [31:0] instr;
        logic        br;
        logic        jp;
        logic        z;
        int          ack_dly;
        int          exec_dly;
        logic [31:0] exp_pc0;
        logic [31:0] exp_pc1;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference next-PC from the architectural rules, using plain arithmetic.
    function automatic logic [31:0] ref_next_pc(input logic [31:0] cur, input logic [31:0] ins,
                                                input logic br, input logic jp, input logic z);
        logic [31:0] p4;
        logic [31:0] off;
        int unsigned op;
        p4  = cur + 32'd4;
        op  = ins >> 26;
        off = (ins & 32'h0000_FFFF);
        if (off >= 32'h8000) off = off - 32'h1_0000;
        if (jp) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
        if (br && ((op == 4 && z) || (op == 5 && !z))) return p4 + off * 4;
        return p4;
    endfunction

    task automatic model_reset();
        m_pc0   = 32'd0;
        m_pc1   = PC1;
        m_cnt   = 32'd0;
        m_instr = 32'd0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"}, {31'd0, a_req}, 32'd0);
        chk({tag, "_valid"}, {31'd0, a_valid}, 32'd0);
        chk({tag, "_pc0"}, a_pc, 32'd0);
        chk({tag, "_pc1"}, b_pc, PC1);
        chk({tag, "_cnt"}, a_cnt, 32'd0);
        chk({tag, "_instr"}, a_instr, 32'd0);
        chk({tag, "_op"}, {26'd0, a_op}, 32'd0);
    endtask

    // Called at a negedge with the DUT in FETCH; returns at a negedge in EXEC.
    task automatic do_fetch(input logic [31:0] word, input int dly);
        for (int i = 0; i < dly; i++) begin
            imem_ack   = 1'b0;
            exec_done  = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            @(negedge clk);
            chk("fetch_wait_req", {31'd0, a_req}, 32'd1);
            chk("fetch_wait_addr", a_addr, m_pc0);
            chk("fetch_wait_valid", {31'd0, a_valid}, 32'd0);
            chk("fetch_wait_cnt", a_cnt, m_cnt);
        end
        exec_done  = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        m_instr    = word;
        chk("fetch_valid", {31'd0, a_valid}, 32'd1);
        chk("fetch_req_low", {31'd0, a_req}, 32'd0);
        chk("fetch_instr", a_instr, word);
        chk("fetch_opcode", {26'd0, a_op}, {26'd0, word[31:26]});
        chk("fetch_instr1", b_instr, word);
    endtask

    // Called at a negedge in EXEC; returns at a negedge in FETCH.
    task automatic do_exec(input logic br, input logic jp, input logic z, input int dly);
        for (int i = 0; i < dly; i++) begin
            exec_done  = 1'b0;
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            branch     = 1'($urandom_range(0, 1));
            jump       = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("exec_wait_valid", {31'd0, a_valid}, 32'd1);
            chk("exec_wait_instr", a_instr, m_instr);
            chk("exec_wait_pc", a_pc, m_pc0);
        end
        imem_ack  = 1'b0;
        exec_done = 1'b1;
        branch    = br;
        jump      = jp;
        zero      = z;
        @(negedge clk);
        exec_done = 1'b0;
        branch    = 1'($urandom_range(0, 1));
        jump      = 1'($urandom_range(0, 1));
        zero      = 1'($urandom_range(0, 1));
        m_pc0 = ref_next_pc(m_pc0, m_instr, br, jp, z);
        m_pc1 = ref_next_pc(m_pc1, m_instr, br, jp, z);
        m_cnt = m_cnt + 32'd1;
        chk("exec_req", {31'd0, b_req}, 32'd1);
        chk("exec_valid", {31'd0, a_valid}, 32'd0);
        chk("exec_addr0", a_addr, m_pc0);
        chk("exec_addr1", b_addr, m_pc1);
        chk("exec_cnt", a_cnt, m_cnt);
        chk("exec_cnt1", b_cnt, m_cnt);
    endtask

    initial begin
        vecs[0]  = '{32'h2008_0005, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0004, 32'hF000_0004};
        vecs[1]  = '{32'h0800_0004, 1'b0, 1'b1, 1'b0, 3, 0, 32'h0000_0010, 32'hF000_0010};
        vecs[2]  = '{32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 0, 2, 32'h0000_000C, 32'hF000_000C};
        vecs[3]  = '{32'h0800_0004, 1'b0, 1'b1, 1'b0, 1, 0, 32'h0000_0010, 32'hF000_0010};
        vecs[4]  = '{32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 0, 1, 32'h0000_0014, 32'hF000_0014};
        vecs[5]  = '{32'h0800_0004, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0000_0010, 32'hF000_0010};
        vecs[6]  = '{32'h1400_FFFE, 1'b1, 1'b0, 1'b0, 2, 0, 32'h0000_000C, 32'hF000_000C};
        vecs[7]  = '{32'h1400_FFFE, 1'b1, 1'b0, 1'b1, 0, 0, 32'h0000_0010, 32'hF000_0010};
        vecs[8]  = '{32'h0000_FFFE, 1'b1, 1'b0, 1'b1, 0, 0, 32'h0000_0014, 32'hF000_0014};
        vecs[9]  = '{32'h0800_0010, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0000_0040, 32'hF000_0040};
        vecs[10] = '{32'h0800_0100, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0000_0400, 32'hF000_0400};
        vecs[11] = '{32'h1000_0100, 1'b1, 1'b1, 1'b1, 0, 0, 32'h0000_0400, 32'hF000_0400};
        vecs[12] = '{32'h0BFF_FFFF, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0FFF_FFFC, 32'hFFFF_FFFC};
        vecs[13] = '{32'h8C00_0000, 1'b0, 1'b0, 1'b0, 0, 0, 32'h1000_0000, 32'h0000_0000};

        #1 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_values("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_first_req", {31'd0, a_req}, 32'd1);
        chk("rst_first_addr", a_addr, 32'd0);
        chk("rst_first_addr1", b_addr, PC1);

        for (int i = 0; i < 14; i++) begin
            do_fetch(vecs[i].instr, vecs[i].ack_dly);
            do_exec(vecs[i].br, vecs[i].jp, vecs[i].z, vecs[i].exec_dly);
            chk($sformatf("vec%0d_pc0", i), a_addr, vecs[i].exp_pc0);
            chk($sformatf("vec%0d_pc1", i), b_addr, vecs[i].exp_pc1);
            chk($sformatf("vec%0d_cnt", i), a_cnt, 32'(i + 1));
        end

        // Counter wrap: preload both counters while sitting in FETCH.
        force u0.r_retire_count = 32'hFFFF_FFFF;
        force u1.r_retire_count = 32'hFFFF_FFFF;
        #1;
        release u0.r_retire_count;
        release u1.r_retire_count;
        #1;
        m_cnt = 32'hFFFF_FFFF;
        chk("wrap_preload", a_cnt, 32'hFFFF_FFFF);
        do_fetch(32'h3400_1234, 0);
        do_exec(1'b0, 1'b0, 1'b0, 0);
        chk("wrap_cnt_zero", a_cnt, 32'd0);

        // Reset in the middle of a stalled fetch.
        do_fetch(32'h0000_0020, 0);
        do_exec(1'b0, 1'b0, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("rst_mid_fetch");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_req", {31'd0, a_req}, 32'd1);
        chk("rst2_addr", a_addr, 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [5:0]  op;
            logic [31:0] ins;
            case ($urandom_range(0, 5))
                0: op = 6'b000000;
                1: op = 6'b000100;
                2: op = 6'b000101;
                3: op = 6'b000010;
                4: op = 6'b001000;
                default: op = 6'b100011;
            endcase
            ins = {op, 26'($urandom)};
            do_fetch(ins, $urandom_range(0, 2));
            do_exec(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        // Reset while an instruction is held: discarded without retiring.
        do_fetch(32'h2008_0005, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("rst_mid_exec");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch and PC-sequencing block for the MIPS-subset datapath. It fetches instruction words from instruction memory over a req/ack handshake and holds the current instruction for the main control decoder and the datapath. It resolves the decoder's Branch/Jump outputs and the ALU zero flag into the next PC, and counts retired instructions. It is the producer of the 6-bit opcode that the main control decoder consumes, and the consumer of that decoder's sequencing outputs.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request, high while waiting for memory.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_ack` in 1: memory returns `imem_rdata` this cycle.
- `imem_rdata` in 32: instruction word.
- `instr` out 32: held instruction register.
- `opcode` out 6: `instr[31:26]`, driven to the main control decoder.
- `instr_valid` out 1: `instr` is live and executing; the datapath gates RegWrite and MemWrite with it.
- `exec_done` in 1: datapath retires the held instruction this cycle.
- `branch`, `jump` in 1 each: decoder Branch and Jump outputs.
- `zero` in 1: ALU zero flag.
- `pc` out 32: address of the held or in-flight instruction.
- `retire_count` out 32: number of retired instructions, wraps modulo 2^32.

## Operation
- States: RST, FETCH, EXEC.
- RST
  - Entered asynchronously whenever `rst_n` is low.
  - Moves to FETCH on the first clock edge with `rst_n` high.
- FETCH
  - `imem_req`=1, `imem_addr`=`pc`; both held stable until ack.
  - On `imem_ack`=1: `instr`←`imem_rdata`, go to EXEC.
- EXEC
  - `instr_valid`=1, `imem_req`=0.
  - On `exec_done`=1: `pc`←next_pc, `retire_count`+1, go to FETCH.
- next_pc is evaluated from `instr`, `pc`, `branch`, `jump` and `zero`, sampled only in the `exec_done` cycle:
  - pc4 = pc+4, modulo 2^32.
  - jump=1 → {pc4[31:28], instr[25:0], 2'b00}. Jump has priority over branch.
  - branch=1 and taken → pc4 + (sign_ext(instr[15:0]) << 2), modulo 2^32.
    - opcode 6'b000100 (beq) is taken when zero=1.
    - opcode 6'b000101 (bne) is taken when zero=0.
    - branch=1 with any other opcode is treated as not taken.
  - Otherwise → pc4. This covers R-type, addi, ori, lui, lw, sw and unrecognised opcodes.
- Ignored inputs:
  - `imem_ack` outside FETCH is ignored.
  - `exec_done` outside EXEC is ignored.
  - `imem_rdata` is don't-care without ack.
- Reset values:
  - `pc`=RESET_PC, `instr`=0 (so `opcode`=0), `instr_valid`=0, `imem_req`=0, `retire_count`=0.
  - All of these are applied asynchronously on `rst_n` falling.
- Reset mid-operation: an outstanding fetch is abandoned (`imem_req` drops immediately) and a held instruction is discarded without retiring. Memory tolerates req withdrawal.

## Timing
- All outputs are registered or decoded from state and registers; there are no combinational input→output paths.
- `opcode` is combinational from `instr` only.
- Fetch latency: ack is allowed in the first FETCH cycle. `instr_valid` rises the cycle after the ack edge.
- Execute: `exec_done` is allowed in the first EXEC cycle. After the `exec_done` edge, `imem_req` is high and `imem_addr` shows next_pc in the next cycle.
- Minimum throughput: one instruction per 2 cycles.
- `instr` is stable for the whole EXEC period. `pc` changes only on the `exec_done` edge.
- First request after reset: `imem_req`=1 in the cycle after the first edge with `rst_n` high.

## Test plan
- **Reset:** hold `rst_n`=0, then release.
  - While low: `pc`=RESET_PC, `imem_req`=0, `instr_valid`=0, `retire_count`=0.
  - One edge after release: `imem_req`=1, `imem_addr`=0.
  - Assert `rst_n`=0 mid-FETCH: outputs clear with no clock.
- **Sequential:** at pc=0, ack with `imem_rdata`=32'h2008_0005 on the first FETCH cycle.
  - Next cycle: `instr_valid`=1, `opcode`=6'b001000.
  - `exec_done` with branch=0, jump=0 → `imem_addr`=32'h4, `retire_count`=1.
- **Branches:** at pc=32'h10 with `instr`=32'h1000_FFFE (beq), branch=1.
  - zero=1 → next pc=32'h0C.
  - zero=0 → next pc=32'h14.
  - `instr`=32'h1400_FFFE (bne), zero=0 → 32'h0C.
- **Jump:**
  - pc=32'h40, `instr`=32'h0800_0100, jump=1 → 32'h400.
  - pc=32'hF000_0000, same instr → 32'hF000_0400.
  - jump=1 with branch=1, zero=1 → jump target wins.
- **Handshake:**
  - ack delayed 3 cycles → `imem_req` and `imem_addr` stable throughout, `instr_valid` stays 0.
  - ack pulsed during EXEC → `instr` unchanged.
  - `exec_done` during FETCH → `pc` and `retire_count` unchanged.
- **Wrap-around:**
  - RESET_PC=32'hFFFF_FFFC, retire a non-branch → next `imem_addr`=32'h0.
  - Preload `retire_count` to 32'hFFFF_FFFF via 2^32−1 retires (or a force) → next retire gives 0.
